// File: rtl/axi_param_pkg.sv
`default_nettype none
// ============================================================================
// axi_param_pkg : register map constants for the multi-channel PS register block
// Revision      : 1.0
// ============================================================================
package axi_param_pkg;

  localparam int MAX_CH = 8;

  localparam logic [7:0] OFS_VERSION    = 8'h00;
  localparam logic [7:0] OFS_CTRL       = 8'h04;
  localparam logic [7:0] OFS_GPIO       = 8'h08;
  localparam logic [7:0] OFS_SYNC_TRIG  = 8'h0C;
  localparam logic [7:0] OFS_SYNC_WIDTH = 8'h10;
  localparam logic [7:0] OFS_STAT       = 8'h14;
  localparam logic [7:0] OFS_MASK       = 8'h18;
  localparam logic [7:0] OFS_DMA_BASE   = 8'h20;
  localparam logic [7:0] OFS_CNT_BASE   = 8'h40;

  function automatic logic [5:0] word_idx(input logic [7:0] ofs);
    return ofs[7:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_pulse_gen.sv
`default_nettype none
// ============================================================================
// sync_pulse_gen : one-shot pulse of programmable width; a retrigger restarts
//                  the count so the pulse is extended without a gap
// Revision       : 1.0
// ============================================================================
module sync_pulse_gen (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trig_i,
  input  logic [7:0] width_i,
  output logic       pulse_o
);

  logic [7:0] cnt_q;

  // Width is captured at trigger time, later width changes leave a live pulse alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (trig_i) begin
      cnt_q <= (width_i == 8'd0) ? 8'd1 : width_i;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign pulse_o = (cnt_q != 8'd0);

endmodule
`default_nettype wire

// File: rtl/axi_param_ctrl_mc.sv
`default_nettype none
// ============================================================================
// axi_param_ctrl_mc : multi-channel PS register block (DMA lengths, sync pulses,
//                     tlast counters/status, IRQ, HP software reset, GPIO enable)
// Revision          : 1.0
// ============================================================================
module axi_param_ctrl_mc
  import axi_param_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter int          SW_RST_CYCLES = 16,
  parameter logic [31:0] VERSION       = 32'h2024_0704
) (
  input  logic                 axiclk,
  input  logic                 rst_n,
  input  logic [31:0]          S_AXI_WDATA_ext,
  input  logic [31:0]          axi_awaddr,
  input  logic [31:0]          axi_araddr,
  input  logic                 slv_reg_wren,
  input  logic                 slv_reg_rden,
  output logic [31:0]          S_AXI_RDATA_ext,
  output logic                 o_hp_sw_rst_n,
  output logic [NUM_CH-1:0]    o_SyncPulse,
  output logic [31:0]          o_GPIO_en,
  output logic [NUM_CH*32-1:0] o_DMA_len,
  input  logic [NUM_CH-1:0]    i_S_AXIS_tlast,
  output logic                 o_irq
);

  localparam logic [5:0] IDX_VERSION    = word_idx(OFS_VERSION);
  localparam logic [5:0] IDX_CTRL       = word_idx(OFS_CTRL);
  localparam logic [5:0] IDX_GPIO       = word_idx(OFS_GPIO);
  localparam logic [5:0] IDX_SYNC_TRIG  = word_idx(OFS_SYNC_TRIG);
  localparam logic [5:0] IDX_SYNC_WIDTH = word_idx(OFS_SYNC_WIDTH);
  localparam logic [5:0] IDX_STAT       = word_idx(OFS_STAT);
  localparam logic [5:0] IDX_MASK       = word_idx(OFS_MASK);
  localparam logic [5:0] IDX_DMA_BASE   = word_idx(OFS_DMA_BASE);
  localparam logic [5:0] IDX_CNT_BASE   = word_idx(OFS_CNT_BASE);
  localparam logic [2:0] GRP_DMA        = IDX_DMA_BASE[5:3];
  localparam logic [2:0] GRP_CNT        = IDX_CNT_BASE[5:3];
  localparam logic [7:0] SWRST_LOAD     = 8'(SW_RST_CYCLES);

  logic [5:0]        widx;
  logic [5:0]        ridx;
  logic [2:0]        wch;
  logic [2:0]        rch;
  logic              we_ctrl;
  logic              we_gpio;
  logic              we_trig;
  logic              we_width;
  logic              we_stat;
  logic              we_mask;
  logic              we_dma_grp;
  logic              we_cnt_grp;
  logic              unused_addr_bits;

  logic [31:0]       gpio_q;
  logic [7:0]        sync_width_q;
  logic [NUM_CH-1:0] stat_q;
  logic [NUM_CH-1:0] stat_d;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] tlast_q;
  logic [NUM_CH-1:0] tlast_rise;
  logic [NUM_CH-1:0] w1c_bits;
  logic [NUM_CH-1:0] sync_trig;
  logic              irq_q;
  logic [7:0]        swrst_cnt_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd_word;
  logic [31:0]       dma_rd [MAX_CH];
  logic [31:0]       cnt_rd [MAX_CH];

  assign widx = axi_awaddr[7:2];
  assign ridx = axi_araddr[7:2];
  assign wch  = widx[2:0];
  assign rch  = ridx[2:0];

  assign unused_addr_bits = ^{axi_awaddr[31:8], axi_awaddr[1:0],
                              axi_araddr[31:8], axi_araddr[1:0]};

  assign we_ctrl    = slv_reg_wren && (widx == IDX_CTRL);
  assign we_gpio    = slv_reg_wren && (widx == IDX_GPIO);
  assign we_trig    = slv_reg_wren && (widx == IDX_SYNC_TRIG);
  assign we_width   = slv_reg_wren && (widx == IDX_SYNC_WIDTH);
  assign we_stat    = slv_reg_wren && (widx == IDX_STAT);
  assign we_mask    = slv_reg_wren && (widx == IDX_MASK);
  assign we_dma_grp = slv_reg_wren && (widx[5:3] == GRP_DMA);
  assign we_cnt_grp = slv_reg_wren && (widx[5:3] == GRP_CNT);

  assign sync_trig  = we_trig ? S_AXI_WDATA_ext[NUM_CH-1:0] : '0;
  assign w1c_bits   = we_stat ? S_AXI_WDATA_ext[NUM_CH-1:0] : '0;
  assign tlast_rise = i_S_AXIS_tlast & ~tlast_q;
  // A new event beats a simultaneous W1C on the same bit
  assign stat_d     = (stat_q & ~w1c_bits) | tlast_rise;

  always_ff @(posedge axiclk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q       <= '0;
      sync_width_q <= 8'd1;
      stat_q       <= '0;
      mask_q       <= '0;
      tlast_q      <= '0;
      irq_q        <= 1'b0;
      swrst_cnt_q  <= 8'd0;
      rdata_q      <= '0;
    end else begin
      tlast_q <= i_S_AXIS_tlast;
      stat_q  <= stat_d;
      irq_q   <= |(stat_q & mask_q);
      if (we_gpio)  gpio_q       <= S_AXI_WDATA_ext;
      if (we_width) sync_width_q <= S_AXI_WDATA_ext[7:0];
      if (we_mask)  mask_q       <= S_AXI_WDATA_ext[NUM_CH-1:0];
      if (we_ctrl && S_AXI_WDATA_ext[0]) begin
        swrst_cnt_q <= SWRST_LOAD;
      end else if (swrst_cnt_q != 8'd0) begin
        swrst_cnt_q <= swrst_cnt_q - 8'd1;
      end
      if (slv_reg_rden) rdata_q <= rd_word;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [31:0] dma_q;
    logic [31:0] cnt_q;
    logic        dma_we;
    logic        cnt_clr;

    assign dma_we  = we_dma_grp && (wch == 3'(ch));
    assign cnt_clr = we_cnt_grp && (wch == 3'(ch));

    // Clearing in the same cycle as an event leaves the count at 1
    always_ff @(posedge axiclk or negedge rst_n) begin
      if (!rst_n) begin
        dma_q <= '0;
        cnt_q <= '0;
      end else begin
        if (dma_we) dma_q <= S_AXI_WDATA_ext;
        if (cnt_clr) begin
          cnt_q <= {31'd0, tlast_rise[ch]};
        end else if (tlast_rise[ch] && (cnt_q != 32'hFFFF_FFFF)) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end

    assign o_DMA_len[32*ch +: 32] = dma_q;
    assign dma_rd[ch]             = dma_q;
    assign cnt_rd[ch]             = cnt_q;

    sync_pulse_gen u_sync (
      .clk_i   (axiclk),
      .rst_ni  (rst_n),
      .trig_i  (sync_trig[ch]),
      .width_i (sync_width_q),
      .pulse_o (o_SyncPulse[ch])
    );
  end

  for (genvar ch = NUM_CH; ch < MAX_CH; ch++) begin : g_absent
    assign dma_rd[ch] = '0;
    assign cnt_rd[ch] = '0;
  end

  always_comb begin
    rd_word = '0;
    case (ridx)
      IDX_VERSION:    rd_word = VERSION;
      IDX_GPIO:       rd_word = gpio_q;
      IDX_SYNC_WIDTH: rd_word[7:0] = sync_width_q;
      IDX_STAT:       rd_word[NUM_CH-1:0] = stat_q;
      IDX_MASK:       rd_word[NUM_CH-1:0] = mask_q;
      default: begin
        if (ridx[5:3] == GRP_DMA) begin
          rd_word = dma_rd[rch];
        end else if (ridx[5:3] == GRP_CNT) begin
          rd_word = cnt_rd[rch];
        end
      end
    endcase
  end

  assign S_AXI_RDATA_ext = rdata_q;
  assign o_hp_sw_rst_n   = (swrst_cnt_q == 8'd0);
  assign o_GPIO_en       = gpio_q;
  assign o_irq           = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_param_ctrl_mc.sv
`default_nettype none
// ============================================================================
// tb_axi_param_ctrl_mc : scoreboard bench with a timestamp-based reference model
// Revision             : 1.0
// ============================================================================
module tb_axi_param_ctrl_mc;

  localparam int          NUM_CH = 4;
  localparam int          SW_RST = 16;
  localparam logic [31:0] VER    = 32'h2024_0704;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [31:0]          wdata = '0;
  logic [31:0]          awaddr = '0;
  logic [31:0]          araddr = '0;
  logic                 wren = 1'b0;
  logic                 rden = 1'b0;
  logic [NUM_CH-1:0]    tlast = '0;
  logic [31:0]          rdata;
  logic                 hp_rst_n;
  logic [NUM_CH-1:0]    sync_pulse;
  logic [31:0]          gpio_en;
  logic [NUM_CH*32-1:0] dma_len;
  logic                 irq;

  always #5 clk = ~clk;

  axi_param_ctrl_mc #(
    .NUM_CH        (NUM_CH),
    .SW_RST_CYCLES (SW_RST),
    .VERSION       (VER)
  ) dut (
    .axiclk          (clk),
    .rst_n           (rst_n),
    .S_AXI_WDATA_ext (wdata),
    .axi_awaddr      (awaddr),
    .axi_araddr      (araddr),
    .slv_reg_wren    (wren),
    .slv_reg_rden    (rden),
    .S_AXI_RDATA_ext (rdata),
    .o_hp_sw_rst_n   (hp_rst_n),
    .o_SyncPulse     (sync_pulse),
    .o_GPIO_en       (gpio_en),
    .o_DMA_len       (dma_len),
    .i_S_AXIS_tlast  (tlast),
    .o_irq           (irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pulses and the software reset are tracked as "active until cycle N"
  int                cyc = 0;
  int                sync_end [NUM_CH];
  int                rst_end = -1;
  logic [7:0]        m_width = 8'd1;
  logic [31:0]       m_gpio = '0;
  logic [31:0]       m_dma [NUM_CH];
  logic [31:0]       m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_stat = '0;
  logic [NUM_CH-1:0] m_mask = '0;
  logic [NUM_CH-1:0] m_prev = '0;
  logic              m_irq = 1'b0;
  logic [31:0]       exp_q [$];
  bit                rd_chk = 1'b0;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      sync_end[c] = -1;
      m_dma[c]    = '0;
      m_cnt[c]    = '0;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned off;
    off = {24'd0, a[7:2], 2'b00};
    if (off == 32'h00) return VER;
    if (off == 32'h08) return m_gpio;
    if (off == 32'h10) return {24'd0, m_width};
    if (off == 32'h14) return {{(32-NUM_CH){1'b0}}, m_stat};
    if (off == 32'h18) return {{(32-NUM_CH){1'b0}}, m_mask};
    if (off >= 32'h20 && off < 32'h20 + 4*NUM_CH) return m_dma[(off - 32'h20) / 4];
    if (off >= 32'h40 && off < 32'h40 + 4*NUM_CH) return m_cnt[(off - 32'h40) / 4];
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned       off;
    logic [NUM_CH-1:0] rise;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync_end[c] = -1;
        m_dma[c]    = '0;
        m_cnt[c]    = '0;
      end
      rst_end = -1;
      m_width = 8'd1;
      m_gpio  = '0;
      m_stat  = '0;
      m_mask  = '0;
      m_prev  = '0;
      m_irq   = 1'b0;
      rd_chk  = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_irq  = |(m_stat & m_mask);
      rd_chk = rden;
      if (rden) exp_q.push_back(model_read(araddr));
      rise   = tlast & ~m_prev;
      m_prev = tlast;
      if (wren) begin
        off = {24'd0, awaddr[7:2], 2'b00};
        if (off == 32'h04 && wdata[0]) rst_end = cyc + SW_RST - 1;
        if (off == 32'h08) m_gpio = wdata;
        if (off == 32'h0C) begin
          for (int c = 0; c < NUM_CH; c++)
            if (wdata[c]) sync_end[c] = cyc + ((m_width == 0) ? 1 : int'(m_width)) - 1;
        end
        if (off == 32'h10) m_width = wdata[7:0];
        if (off == 32'h14) m_stat = m_stat & ~wdata[NUM_CH-1:0];
        if (off == 32'h18) m_mask = wdata[NUM_CH-1:0];
        if (off >= 32'h20 && off < 32'h20 + 4*NUM_CH) m_dma[(off - 32'h20) / 4] = wdata;
        if (off >= 32'h40 && off < 32'h40 + 4*NUM_CH) m_cnt[(off - 32'h40) / 4] = '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (rise[c]) begin
          if (m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c] = m_cnt[c] + 1;
          m_stat[c] = 1'b1;
        end
      end
    end
  end

  // Monitor: pops a read expectation whenever a read was presented, and checks all outputs
  logic [31:0] rd_hold = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_hold = '0;
    end else if (rd_chk) begin
      if (exp_q.size() == 0) check("rd_queue_empty", 1, 0);
      else rd_hold = exp_q.pop_front();
    end
    check("rdata", rdata, rd_hold);
    for (int c = 0; c < NUM_CH; c++) begin
      check("sync_pulse", sync_pulse[c], (cyc <= sync_end[c]));
      check("dma_len", dma_len[32*c +: 32], m_dma[c]);
    end
    check("hp_sw_rst_n", hp_rst_n, !(cyc <= rst_end));
    check("irq", irq, m_irq);
    check("gpio_en", gpio_en, m_gpio);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    awaddr = a;
    wdata  = d;
    wren   = 1'b1;
    tick();
    wren   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    araddr = a;
    rden   = 1'b1;
    tick();
    rden   = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int          n0, n2, lo;
    logic [31:0] a, d;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset values and read latency
    check("reset_hp_rst_n", hp_rst_n, 1);
    check("reset_rdata", rdata, 0);
    rd(32'h00); check("rd_version", rdata, VER);
    rd(32'h10); check("rd_sync_width_reset", rdata, 1);
    rd(32'h08); check("rd_gpio_reset", rdata, 0);

    // DMA length and GPIO
    wr(32'h24, 32'h0000_1000);
    wr(32'h08, 32'h0000_00A5);
    check("dma_len_ch1", dma_len[63:32], 32'h1000);
    check("gpio_a5", gpio_en, 32'hA5);
    wr(32'h2C, 32'hDEAD_BEEF);
    wr(32'h30, 32'h1234_5678);
    rd(32'h2C); check("rd_dma_ch3", rdata, 32'hDEAD_BEEF);
    rd(32'h30); check("rd_dma_ch4_absent", rdata, 0);

    // Sync pulses with retrigger on channel 0
    wr(32'h10, 32'd3);
    wr(32'h0C, 32'h5);
    n0 = int'(sync_pulse[0]); n2 = int'(sync_pulse[2]);
    tick();
    n0 += int'(sync_pulse[0]); n2 += int'(sync_pulse[2]);
    wr(32'h0C, 32'h1);
    repeat (8) begin
      n0 += int'(sync_pulse[0]); n2 += int'(sync_pulse[2]);
      tick();
    end
    check("sync_ch0_retrig_len", n0, 5);
    check("sync_ch2_len", n2, 3);

    // Software reset, single and retriggered
    wr(32'h04, 32'h1);
    lo = 0;
    repeat (20) begin lo += int'(!hp_rst_n); tick(); end
    check("swrst_len", lo, 16);
    wr(32'h04, 32'h1);
    lo = 0;
    repeat (9) begin lo += int'(!hp_rst_n); tick(); end
    lo += int'(!hp_rst_n);
    wr(32'h04, 32'h1);
    repeat (20) begin lo += int'(!hp_rst_n); tick(); end
    check("swrst_retrig_len", lo, 26);

    // tlast events, sticky status, interrupt latency
    wr(32'h14, 32'hF);
    wr(32'h18, 32'h2);
    tlast = 4'b0010;
    tick(); check("irq_before", irq, 0);
    tick(); check("irq_after", irq, 1);
    tick(); tlast = '0;
    tick(); tick();
    tlast = 4'b0010;
    repeat (3) tick();
    tlast = '0;
    tick();
    rd(32'h44); check("rd_tlast_cnt1", rdata, 2);
    rd(32'h14); check("rd_stat", rdata, 32'b0010);
    tlast = 4'b0010;
    wr(32'h14, 32'h2);
    tlast = '0;
    tick();
    rd(32'h14); check("stat_set_wins", rdata, 32'b0010);
    tlast = 4'b0010;
    wr(32'h44, 32'h0);
    tlast = '0;
    tick();
    rd(32'h44); check("cnt_clear_with_event", rdata, 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      tlast = NUM_CH'($urandom);
      a = {24'd0, 6'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FF00);
      d = $urandom;
      if (a[7:0] == 8'h10) d = $urandom_range(0, 6);
      case ($urandom_range(0, 3))
        0:       rd(a);
        1, 2:    wr(a, d);
        default: tick();
      endcase
    end
    tlast = '0;
    repeat (30) tick();

    // Asynchronous reset during active pulses
    wr(32'h10, 32'd10);
    wr(32'h0C, 32'hF);
    wr(32'h04, 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sync", sync_pulse, 0);
    check("async_rst_hp", hp_rst_n, 1);
    check("async_rst_dma", dma_len, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(32'h10); check("rd_width_after_rst", rdata, 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
